wave_nco: RTL and testbench
===========================

WAVE_NCO -- requirements
Module: wave_nco

Interface
REQ-001 Parameter ACC_W, default 24, phase accumulator width.
REQ-002 Parameter PHASE_W, default 8, phase index width; 3 <= PHASE_W <= ACC_W.
REQ-003 Parameter OUT_W, default 8, output sample width; OUT_W <= PHASE_W.
REQ-004 Parameter DIV_W, default 16, sample-rate divider width.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high.
REQ-007 Port control, input, DIV_W, divider terminal count; sample rate = clk/(control+1).
REQ-008 Port tuning, input, ACC_W, phase increment per sample.
REQ-009 Port phase_offset, input, PHASE_W, phase added to the index.
REQ-010 Port wave_sel, input, 2, waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-011 Port sync, input, 1, phase restart.
REQ-012 Port amplitude, output, OUT_W, registered offset-binary sample; midscale M = 2^(OUT_W-1).
REQ-013 Port sample_valid, output, 1, one-cycle strobe marking a new amplitude value.

Function
REQ-014 Divider: count increments each cycle; when count >= control, tick asserts, count <= 0.
REQ-015 On tick: acc <= acc + tuning mod 2^ACC_W.
REQ-016 Index p = acc[ACC_W-1 -: PHASE_W] + phase_offset mod 2^PHASE_W, using post-update acc.
REQ-017 Latency: amplitude and sample_valid update on the clock edge after the tick edge; sample_valid high exactly 1 cycle per tick.
REQ-018 wave_sel and phase_offset are sampled on the same cycle as p.
REQ-019 Sine: quarter-wave LUT of 2^(PHASE_W-2) entries; q = p[PHASE_W-2] ? ~p[PHASE_W-3:0] : p[PHASE_W-3:0].
REQ-020 LUT entry s(q) = round((M-1)*sin(pi/2*(q+0.5)/2^(PHASE_W-2))).
REQ-021 Sine output = p[PHASE_W-1]==0 ? M+s : M-1-s.
REQ-022 Square output = p[PHASE_W-1]==0 ? 2^OUT_W-1 : 0.
REQ-023 Triangle: t = p[PHASE_W-1] ? ~p[PHASE_W-2:0] : p[PHASE_W-2:0]; output = top OUT_W bits of {t,1'b0}.
REQ-024 Sawtooth output = p[PHASE_W-1 -: OUT_W].
REQ-025 sync high: acc <= 0, count <= 0, no tick that cycle; sync wins over a simultaneous tick.
REQ-026 control lowered below the current count: tick on the next cycle (>= compare, no wrap stall).
REQ-027 control = 0: tick every cycle; sample_valid continuously high after the first sample.
REQ-028 Accumulator overflow wraps silently; no flag.

Reset
REQ-029 reset: count=0, acc=0, amplitude=M, sample_valid=0; the output pipeline is also cleared.
REQ-030 reset asserted mid-operation takes priority over sync and tick on that edge; the first tick occurs control+1 cycles after deassertion.

Configuration
REQ-031 Macro NCO_AM_EN: defined adds input gain[OUT_W-1:0] and a multiplier stage.
- Output = M + ((signed(raw-M) * gain) >>> OUT_W).
- Latency becomes 2 cycles after the tick; sample_valid is delayed to match.
- The stage resets to M/0.
REQ-032 NCO_AM_EN undefined: no gain port, latency per REQ-017.

Verification (defaults 24/8/8/16)
REQ-033 Reset held 3 cycles -> amplitude=0x80, sample_valid=0.
REQ-034 Sawtooth step (control=3, tuning=0x010000, wave_sel=3) -> sample_valid every 4th cycle; amplitude 0x01, 0x02, 0x03, ...
REQ-035 Sine sweep (control=0, tuning=0x010000, wave_sel=0), full 256-sample sweep:
- p=0x00 gives 0x82; p=0x3F and 0x40 give 0xFF.
- p=0xBF and 0xC0 give 0x00.
- The sweep is symmetric per REQ-021.
REQ-036 Square (tuning=0x400000, wave_sel=1) -> p 0x40, 0x80, 0xC0, 0x00 give 0xFF, 0x00, 0x00, 0xFF.
- phase_offset=0x40 shifts the sequence by one sample.
REQ-037 sync asserted on a tick cycle -> no sample_valid that cycle; the next tick gives p=tuning step (0x01 sawtooth).
REQ-038 control changed 1000->2 while count=500 -> tick next cycle, then every 3 cycles.

Source files
------------

// File: rtl/wave_nco_if.sv
// Signal bundle for the wave_nco numerically controlled oscillator.
// The gain input exists only when NCO_AM_EN is defined.
interface wave_nco_if #(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8,
    parameter int DIV_W   = 16
);
    logic [DIV_W-1:0]   control;
    logic [ACC_W-1:0]   tuning;
    logic [PHASE_W-1:0] phase_offset;
    logic [1:0]         wave_sel;
    logic               sync;
    logic [OUT_W-1:0]   amplitude;
    logic               sample_valid;
`ifdef NCO_AM_EN
    logic [OUT_W-1:0]   gain;

    modport master (
        output control, tuning, phase_offset, wave_sel, sync, gain,
        input  amplitude, sample_valid
    );
    modport slave (
        input  control, tuning, phase_offset, wave_sel, sync, gain,
        output amplitude, sample_valid
    );
`else
    modport master (
        output control, tuning, phase_offset, wave_sel, sync,
        input  amplitude, sample_valid
    );
    modport slave (
        input  control, tuning, phase_offset, wave_sel, sync,
        output amplitude, sample_valid
    );
`endif
endinterface

// File: rtl/wave_nco.sv
// Divided-rate phase accumulator NCO with sine/square/triangle/sawtooth shaping.
// Optional amplitude modulation stage enabled by defining NCO_AM_EN.
module wave_nco #(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8,
    parameter int DIV_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    wave_nco_if.slave  bus
);
    localparam int QN = 2 ** (PHASE_W - 2);
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    // Quarter-wave entry round((M-1)*sin(pi/2*(q+0.5)/QN)), evaluated at
    // elaboration with a Q30 fixed-point Taylor series.
    function automatic logic [OUT_W-1:0] sine_entry(input int q);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        x    = (longint'(1686629713) * longint'(2 * q + 1)) >>> (PHASE_W - 1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        scaled = sum * longint'((2 ** (OUT_W - 1)) - 1);
        return OUT_W'((scaled + (longint'(1) <<< 29)) >>> 30);
    endfunction

`ifdef NCO_AM_EN
    function automatic logic [OUT_W-1:0] am_scale(input logic [OUT_W-1:0] raw,
                                                  input logic [OUT_W-1:0] g);
        logic signed [OUT_W:0]     centred;
        logic signed [2*OUT_W+1:0] prod;
        centred = $signed({1'b0, raw}) - $signed({1'b0, MID});
        prod    = centred * $signed({1'b0, g});
        return OUT_W'($signed({1'b0, MID}) + (prod >>> OUT_W));
    endfunction
`endif

    logic [OUT_W-1:0] sine_lut [QN];

    for (genvar g = 0; g < QN; g++) begin : g_lut
        assign sine_lut[g] = sine_entry(g);
    end

    logic [DIV_W-1:0]   count;
    logic [ACC_W-1:0]   acc;
    logic               tick;
    logic               vld_p0;
    logic [PHASE_W-1:0] p_p0;
    logic [PHASE_W-3:0] q_p0;
    logic [PHASE_W-2:0] t_p0;
    logic [PHASE_W-1:0] tri_p0;
    logic [OUT_W-1:0]   raw_p0;
    logic [OUT_W-1:0]   raw_p1;
    logic               vld_p1;

    // sync suppresses the tick; the >= compare ticks at once when control drops
    assign tick = !bus.sync && (count >= bus.control);

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            vld_p0 <= 1'b0;
        end else if (bus.sync) begin
            count  <= '0;
            acc    <= '0;
            vld_p0 <= 1'b0;
        end else if (tick) begin
            count  <= '0;
            acc    <= acc + bus.tuning;
            vld_p0 <= 1'b1;
        end else begin
            count  <= count + DIV_W'(1);
            vld_p0 <= 1'b0;
        end
    end

    // ---- stage p0 -> p1: phase index from the post-tick accumulator, waveform shaping
    assign p_p0   = acc[ACC_W-1 -: PHASE_W] + bus.phase_offset;
    assign q_p0   = p_p0[PHASE_W-2] ? ~p_p0[PHASE_W-3:0] : p_p0[PHASE_W-3:0];
    assign t_p0   = p_p0[PHASE_W-1] ? ~p_p0[PHASE_W-2:0] : p_p0[PHASE_W-2:0];
    assign tri_p0 = {t_p0, 1'b0};

    always_comb begin
        raw_p0 = MID;
        case (bus.wave_sel)
            2'd0: raw_p0 = p_p0[PHASE_W-1] ? (MID - OUT_W'(1) - sine_lut[q_p0])
                                           : (MID + sine_lut[q_p0]);
            2'd1: raw_p0 = p_p0[PHASE_W-1] ? '0 : '1;
            2'd2: raw_p0 = tri_p0[PHASE_W-1 -: OUT_W];
            default: raw_p0 = p_p0[PHASE_W-1 -: OUT_W];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_p1 <= MID;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                raw_p1 <= raw_p0;
            end
        end
    end

`ifdef NCO_AM_EN
    logic [OUT_W-1:0] amp_p2;
    logic             vld_p2;

    // ---- stage p1 -> p2: amplitude modulation around midscale
    always_ff @(posedge clk) begin
        if (reset) begin
            amp_p2 <= MID;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                amp_p2 <= am_scale(raw_p1, bus.gain);
            end
        end
    end

    assign bus.amplitude    = amp_p2;
    assign bus.sample_valid = vld_p2;
`else
    assign bus.amplitude    = raw_p1;
    assign bus.sample_valid = vld_p1;
`endif

endmodule

// File: tb/tb_wave_nco.sv
// Randomized scoreboard bench for wave_nco: an arithmetic reference model queues
// expected samples (value and due cycle), a monitor pops them on sample_valid.
module tb_wave_nco;
    localparam int ACC_W   = 24;
    localparam int PHASE_W = 8;
    localparam int OUT_W   = 8;
    localparam int DIV_W   = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wave_nco_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) bus ();

    wave_nco #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         due;
        logic [7:0] val;
        logic [7:0] p;
        logic [1:0] ws;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] hist[$];
    int         htime[$];
    int         sine_cap[256];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;

    int         m_count = 0;
    logic [23:0] m_acc  = '0;
    bit         m_pend  = 1'b0;

    function automatic logic [7:0] ref_wave(input logic [1:0] ws, input logic [7:0] p);
        int pi_;
        int q;
        int s;
        int t;
        pi_ = int'(p);
        case (ws)
            2'd0: begin
                q = (pi_ & 64) != 0 ? 63 - (pi_ % 64) : pi_ % 64;
                s = int'(127.0 * $sin(3.14159265358979 * (q + 0.5) / 128.0));
                return (pi_ >= 128) ? 8'(127 - s) : 8'(128 + s);
            end
            2'd1: return (pi_ >= 128) ? 8'd0 : 8'd255;
            2'd2: begin
                t = (pi_ >= 128) ? 127 - (pi_ % 128) : pi_ % 128;
                return 8'(2 * t);
            end
            default: return p;
        endcase
    endfunction

    // reference: divider, accumulator and sample emission one edge after each tick
    initial forever begin
        logic [7:0] pp;
        @(posedge clk);
        cyc = cyc + 1;
        if (reset) begin
            m_count = 0;
            m_acc   = '0;
            m_pend  = 1'b0;
        end else begin
            if (m_pend) begin
                pp = m_acc[23:16] + bus.phase_offset;
                sb.push_back('{due: cyc, val: ref_wave(bus.wave_sel, pp), p: pp, ws: bus.wave_sel});
            end
            if (bus.sync) begin
                m_count = 0;
                m_acc   = '0;
                m_pend  = 1'b0;
            end else if (m_count >= int'(bus.control)) begin
                m_count = 0;
                m_acc   = m_acc + bus.tuning;
                m_pend  = 1'b1;
            end else begin
                m_count = m_count + 1;
                m_pend  = 1'b0;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.sample_valid) begin
            hist.push_back(bus.amplitude);
            htime.push_back(cyc);
            tests = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_sample cyc=%0d: got amplitude %02h, required no sample", cyc, bus.amplitude);
            end else begin
                e = sb.pop_front();
                if (bus.amplitude !== e.val || e.due != cyc) begin
                    fails = fails + 1;
                    $display("FAIL sample p=%02h ws=%0d: got %02h at cyc %0d, required %02h at cyc %0d",
                             e.p, e.ws, bus.amplitude, cyc, e.val, e.due);
                end
                if (e.ws == 2'd0) sine_cap[e.p] = int'(bus.amplitude);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missing_sample: got no sample_valid at cyc %0d, required %02h due cyc %0d", cyc, e.val, e.due);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_hist(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (hist.size() < target && k < budget) begin
            step();
            k++;
        end
        check({name, "_arrived"}, int'(hist.size() >= target), 1);
    endtask

    task automatic wait_count(input int value, input int budget, input string name);
        int k;
        k = 0;
        while (m_count != value && k < budget) begin
            step();
            k++;
        end
        check({name, "_count_reached"}, m_count, value);
    endtask

    task automatic sync_pulse();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
    endtask

    initial begin
        int hs;
        int c;
        int bad;

        reset            = 1'b1;
        bus.control      = 16'd3;
        bus.tuning       = 24'h010000;
        bus.phase_offset = 8'h00;
        bus.wave_sel     = 2'd3;
        bus.sync         = 1'b0;
        foreach (sine_cap[i]) sine_cap[i] = -1;
        repeat (3) step();
        check("reset_amplitude", int'(bus.amplitude), 'h80);
        check("reset_valid", int'(bus.sample_valid), 0);
        reset = 1'b0;

        // sawtooth staircase at clk/4
        hs = hist.size();
        wait_hist(hs + 3, 40, "saw");
        check("saw_third_value", int'(hist[hs + 2]), 'h03);
        check("saw_spacing", htime[hs + 2] - htime[hs + 1], 4);

        // full sine sweep, one sample per clock
        bus.control  = 16'd0;
        bus.wave_sel = 2'd0;
        sync_pulse();
        foreach (sine_cap[i]) sine_cap[i] = -1;
        hs = hist.size();
        wait_hist(hs + 260, 400, "sine");
        check("sine_p00", sine_cap[8'h00], 'h82);
        check("sine_p3f", sine_cap[8'h3F], 'hFF);
        check("sine_p40", sine_cap[8'h40], 'hFF);
        check("sine_pbf", sine_cap[8'hBF], 'h00);
        check("sine_pc0", sine_cap[8'hC0], 'h00);
        bad = 0;
        for (int i = 0; i < 128; i++) if (sine_cap[i] + sine_cap[i + 128] != 255) bad++;
        check("sine_symmetry_errors", bad, 0);

        // square, then shifted by a quarter turn
        bus.wave_sel = 2'd1;
        bus.tuning   = 24'h400000;
        sync_pulse();
        hs = hist.size();
        wait_hist(hs + 4, 20, "square");
        check("square_seq", {hist[hs], hist[hs + 1], hist[hs + 2], hist[hs + 3]}, 32'hFF0000FF);
        bus.phase_offset = 8'h40;
        sync_pulse();
        hs = hist.size();
        wait_hist(hs + 4, 20, "square_ofs");
        check("square_ofs_seq", {hist[hs], hist[hs + 1], hist[hs + 2], hist[hs + 3]}, 32'h0000FFFF);

        // sync landing on a tick cycle
        bus.phase_offset = 8'h00;
        bus.wave_sel     = 2'd3;
        bus.tuning       = 24'h010000;
        bus.control      = 16'd3;
        wait_count(3, 20, "sync_tick");
        sync_pulse();
        hs = hist.size();
        step();
        check("sync_no_valid", int'(bus.sample_valid), 0);
        wait_hist(hs + 1, 20, "sync_next");
        check("sync_next_value", int'(hist[hs]), 'h01);

        // divider terminal count lowered below the running count
        bus.control = 16'd1000;
        sync_pulse();
        wait_count(500, 1200, "ctl_change");
        bus.control = 16'd2;
        c  = cyc;
        hs = hist.size();
        wait_hist(hs + 3, 30, "ctl_change");
        check("ctl_first_sample_cyc", htime[hs], c + 2);
        check("ctl_gap1", htime[hs + 1] - htime[hs], 3);
        check("ctl_gap2", htime[hs + 2] - htime[hs + 1], 3);

        // reset in the middle of operation
        bus.control = 16'd3;
        repeat (10) step();
        reset = 1'b1;
        step();
        check("midreset_amplitude", int'(bus.amplitude), 'h80);
        check("midreset_valid", int'(bus.sample_valid), 0);
        reset = 1'b0;
        c  = cyc;
        hs = hist.size();
        wait_hist(hs + 1, 20, "midreset");
        check("midreset_first_cyc", htime[hs], c + 5);
        check("midreset_first_value", int'(hist[hs]), 'h01);

        // randomized operation against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) bus.control = DIV_W'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) bus.tuning = 24'($urandom);
            if ($urandom_range(0, 9) == 0) bus.wave_sel = 2'($urandom);
            if ($urandom_range(0, 9) == 0) bus.phase_offset = 8'($urandom);
            bus.sync = ($urandom_range(0, 29) == 0);
            reset    = ($urandom_range(0, 399) == 0);
            step();
        end
        reset    = 1'b0;
        bus.sync = 1'b0;
        repeat (8) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
